// File: rtl/adder_link_initiator.sv
// Host-side initiator for the two-operand adder link: sends A then B over the
// uart tx stream, waits for the one-byte sum, and checks it or times out.
module adder_link_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned CNT_W          = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic       req_valid,
   output logic       req_ready,
   output logic [7:0] tx_tdata,
   output logic       tx_tvalid,
   input  logic       tx_tready,
   input  logic [7:0] rx_tdata,
   input  logic       rx_tvalid,
   output logic       rx_tready,
   output logic [7:0] rsp_data,
   output logic       rsp_valid,
   output logic       rsp_error,
   output logic       rsp_timeout,
   output logic [7:0] stray_cnt,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_RSP} state_e;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [7:0]       b_q, b_d;
   logic [7:0]       exp_q, exp_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_error_q, rsp_error_d;
   logic             rsp_tmo_q, rsp_tmo_d;
   logic [7:0]       stray_q, stray_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      exp_d       = exp_q;
      timer_d     = timer_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_tmo_d   = 1'b0;
      stray_d     = stray_q;

      // Only WAIT_RSP consumes rx bytes; anything else is counted and dropped.
      if (rx_tvalid && state_q != WAIT_RSP && stray_q != 8'hFF)
         stray_d = stray_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               b_d        = req_b;
               exp_d      = req_a + req_b;
               tx_data_d  = req_a;
               tx_valid_d = 1'b1;
               state_d    = SEND_A;
            end
         end
         SEND_A: begin
            if (tx_tready) begin
               tx_data_d = b_q;
               state_d   = SEND_B;
            end
         end
         SEND_B: begin
            if (tx_tready) begin
               tx_valid_d = 1'b0;
               timer_d    = '0;
               state_d    = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            timer_d = timer_q + CNT_ONE;
            // A response in the final timer cycle still wins over the timeout.
            if (rx_tvalid) begin
               rsp_data_d  = rx_tdata;
               rsp_valid_d = 1'b1;
               rsp_error_d = (rx_tdata != exp_q);
               state_d     = IDLE;
            end else if (timer_q == TMO_LAST) begin
               rsp_tmo_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         b_q         <= '0;
         exp_q       <= '0;
         timer_q     <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         stray_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         exp_q       <= exp_d;
         timer_q     <= timer_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_tmo_q   <= rsp_tmo_d;
         stray_q     <= stray_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign rx_tready   = 1'b1;
   assign tx_tdata    = tx_data_q;
   assign tx_tvalid   = tx_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_tmo_q;
   assign stray_cnt   = stray_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_adder_link_initiator.sv
// Directed plus randomized transactions checked against a transaction-level
// model: byte order on tx, sum/mismatch, timeout window and stray counting.
module tb_adder_link_initiator;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_a = '0, req_b = '0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] tx_tdata;
   logic       tx_tvalid;
   logic       tx_tready = 1'b0;
   logic [7:0] rx_tdata = '0;
   logic       rx_tvalid = 1'b0;
   logic       rx_tready;
   logic [7:0] rsp_data;
   logic       rsp_valid, rsp_error, rsp_timeout;
   logic [7:0] stray_cnt;
   logic       busy;

   int errs = 0;
   int checks = 0;
   int stray_m = 0;
   logic [7:0] last_rsp = '0;

   adder_link_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(24)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready),
      .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
      .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
      .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stray_hit();
      if (stray_m < 255) stray_m++;
   endtask

   // One full transaction. delay = wait-phase cycle on which the response is
   // driven (>= T means no response). rnd = random tx back-pressure.
   task automatic txn(input logic [7:0] a, input logic [7:0] b, input int stall,
                      input int delay, input logic [7:0] rsp, input bit stray_send,
                      input bit stray_after, input bit rnd);
      logic [7:0] bytes [2];
      logic [7:0] sum;
      int idx, cyc, n;
      bit stray_done;
      sum = 8'((int'(a) + int'(b)) % 256);
      bytes[0] = a;
      bytes[1] = b;
      idx = 0;
      cyc = 0;
      stray_done = 0;

      chk("req_ready_idle", req_ready, 1);
      chk("busy_idle", busy, 0);
      req_a = a; req_b = b; req_valid = 1'b1;
      step();

      while (idx < 2) begin
         chk("tx_tvalid_send", tx_tvalid, 1);
         chk("tx_tdata_send", tx_tdata, bytes[idx]);
         chk("busy_send", busy, 1);
         chk("req_ready_send", req_ready, 0);
         req_valid = 1'($urandom_range(0, 1));
         req_a = 8'($urandom); req_b = 8'($urandom);
         if (idx == 0 && cyc < stall) tx_tready = 1'b0;
         else if (rnd) tx_tready = ($urandom_range(0, 3) != 0);
         else tx_tready = 1'b1;
         if (stray_send && idx == 1 && !stray_done) begin
            rx_tvalid = 1'b1; rx_tdata = 8'hAA; stray_hit(); stray_done = 1;
         end else rx_tvalid = 1'b0;
         if (tx_tready) idx++;
         cyc++;
         step();
         if (cyc > 200) begin
            chk("send_budget", cyc, 0);
            break;
         end
      end
      tx_tready = 1'($urandom_range(0, 1));
      rx_tvalid = 1'b0;

      n = 0;
      forever begin
         chk("tx_tvalid_wait", tx_tvalid, 0);
         chk("busy_wait", busy, 1);
         chk("rsp_valid_wait", rsp_valid, 0);
         chk("rsp_timeout_wait", rsp_timeout, 0);
         chk("rx_tready", rx_tready, 1);
         req_valid = 1'($urandom_range(0, 1));
         if (n == delay && delay < T) begin
            rx_tvalid = 1'b1; rx_tdata = rsp;
            step();
            rx_tvalid = 1'b0;
            break;
         end
         if (n == T - 1) begin
            step();
            break;
         end
         n++;
         step();
      end

      req_valid = 1'b0;
      if (delay < T) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_data", rsp_data, rsp);
         chk("rsp_error", rsp_error, (rsp != sum));
         chk("rsp_timeout_resp", rsp_timeout, 0);
         last_rsp = rsp;
      end else begin
         chk("rsp_timeout", rsp_timeout, 1);
         chk("rsp_valid_tmo", rsp_valid, 0);
         chk("rsp_data_tmo", rsp_data, last_rsp);
      end
      chk("req_ready_after", req_ready, 1);
      chk("busy_after", busy, 0);
      if (stray_after) begin
         rx_tvalid = 1'b1; rx_tdata = 8'h55; stray_hit();
      end
      step();
      rx_tvalid = 1'b0;
      chk("rsp_valid_pulse", rsp_valid, 0);
      chk("rsp_timeout_pulse", rsp_timeout, 0);
      chk("stray_cnt", stray_cnt, stray_m);
   endtask

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst_tx_tvalid", tx_tvalid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_stray", stray_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      step(); step();
      rst = 1'b1;
      step();

      // Normal: request at cycle 0, response at cycle 10 (wait-phase cycle 7).
      txn(8'h12, 8'h34, 0, 7, 8'h46, 0, 0, 0);
      // Wrap, then mismatch.
      txn(8'hFF, 8'h02, 0, 3, 8'h01, 0, 0, 0);
      txn(8'h10, 8'h20, 0, 2, 8'h31, 0, 0, 0);
      // Back-pressure on A for 5 cycles.
      txn(8'hA5, 8'h5A, 5, 1, 8'hFF, 0, 0, 0);
      // Timeout, then response on the last wait cycle.
      txn(8'h01, 8'h02, 0, T, 8'h00, 0, 0, 0);
      txn(8'h03, 8'h04, 0, T - 1, 8'h07, 0, 0, 0);
      // Stray in IDLE, then during SEND_B, then one right after capture.
      rx_tvalid = 1'b1; rx_tdata = 8'hAA; stray_hit();
      step();
      rx_tvalid = 1'b0;
      txn(8'h22, 8'h33, 0, 4, 8'h55, 1, 1, 0);
      // Saturation.
      rx_tvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rx_tdata = 8'($urandom);
         stray_hit();
         step();
      end
      rx_tvalid = 1'b0;
      chk("stray_sat", stray_cnt, 255);
      chk("stray_sat_model", stray_cnt, stray_m);

      // Reset during SEND_B with tx stalled.
      req_a = 8'h77; req_b = 8'h88; req_valid = 1'b1;
      step();
      req_valid = 1'b0; tx_tready = 1'b1;
      step();
      tx_tready = 1'b0;
      step();
      chk("pre_rst_tvalid", tx_tvalid, 1);
      chk("pre_rst_tdata", tx_tdata, 8'h88);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_tvalid", tx_tvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_stray", stray_cnt, 0);
      stray_m = 0;
      last_rsp = '0;
      step(); step();
      rst = 1'b1;
      tx_tready = 1'b1;
      step();
      chk("post_rst_tvalid", tx_tvalid, 0);
      txn(8'h01, 8'h01, 0, 3, 8'h02, 0, 0, 0);

      // Randomized transactions.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb, rr;
         int d;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rr = ($urandom_range(0, 1) != 0) ? 8'((int'(ra) + int'(rb)) % 256) : 8'($urandom);
         d = $urandom_range(0, T + 2);
         txn(ra, rb, $urandom_range(0, 3), d, rr,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      errs++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "global timeout");
   end
endmodule
